// File: rtl/fourbit_4bit_adder.sv
// Registered 4-bit ripple-carry adder/subtractor built from four full-adder cells.
// Operands are sampled on the rising edge; sum and flags appear one cycle later.
module fourbit_4bit_adder (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_A,
  input  logic [3:0] i_B,
  input  logic       i_Cin,
  input  logic       i_sub,
  output logic [3:0] o_sum,
  output logic       o_carry,
  output logic       o_overflow,
  output logic       o_zero
);

  logic [3:0] w_b;
  logic [4:0] w_c;
  logic [3:0] w_s;

  // Subtract is A + ~B + ~Cin, so B and the borrow-in are inverted by i_sub.
  assign w_b    = i_B ^ {4{i_sub}};
  assign w_c[0] = i_Cin ^ i_sub;

  for (genvar g = 0; g < 4; g++) begin : g_cell
    assign w_s[g]   = i_A[g] ^ w_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_A[g] & w_b[g]) | (w_c[g] & (i_A[g] ^ w_b[g]));
  end

  logic [3:0] r_sum;
  logic       r_carry;
  logic       r_overflow;
  logic       r_zero;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sum      <= 4'h0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      r_sum      <= w_s;
      r_carry    <= w_c[4];
      r_overflow <= w_c[3] ^ w_c[4];
      r_zero     <= (w_s == 4'h0);
    end
  end

  assign o_sum      = r_sum;
  assign o_carry    = r_carry;
  assign o_overflow = r_overflow;
  assign o_zero     = r_zero;

endmodule

// File: tb/tb_fourbit_4bit_adder.sv
// Bench for fourbit_4bit_adder: directed steps with hand-computed results, then an
// exhaustive sweep against an arithmetic reference model, through an expected queue.
module tb_fourbit_4bit_adder;

  logic       i_clk;
  logic       i_reset;
  logic [3:0] i_A;
  logic [3:0] i_B;
  logic       i_Cin;
  logic       i_sub;
  logic [3:0] o_sum;
  logic       o_carry;
  logic       o_overflow;
  logic       o_zero;

  // Expected word layout: {sum[3:0], carry, overflow, zero}
  logic [6:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  fourbit_4bit_adder dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_A        (i_A),
    .i_B        (i_B),
    .i_Cin      (i_Cin),
    .i_sub      (i_sub),
    .o_sum      (o_sum),
    .o_carry    (o_carry),
    .o_overflow (o_overflow),
    .o_zero     (o_zero)
  );

  // clock/reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam logic [6:0] RST_VEC = {4'h0, 1'b0, 1'b0, 1'b1};

  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin, input logic sub);
    int ua, ub, sa, sb, r, sr;
    logic [3:0] s;
    logic c, v, z;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      r  = ua + ub + int'(cin);
      c  = (r > 15);
      sr = sa + sb + int'(cin);
    end else begin
      r  = ua - ub - int'(cin);
      c  = (r >= 0);
      sr = sa - sb - int'(cin);
    end
    s = r[3:0];
    v = (sr > 7) || (sr < -8);
    z = (s == 4'h0);
    return {s, c, v, z};
  endfunction

  task automatic check(input string tag);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {o_sum, o_carry, o_overflow, o_zero};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h (A=%h B=%h Cin=%b sub=%b rst=%b)",
               tag, obs, exp, i_A, i_B, i_Cin, i_sub, i_reset);
      end
    end
  endtask

  // driver: present one operation, queue its expected result, check it after the edge
  task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                      input logic cin, input logic sub, input logic [6:0] exp,
                      input string tag);
    i_reset = rst;
    i_A     = a;
    i_B     = b;
    i_Cin   = cin;
    i_sub   = sub;
    exp_q.push_back(exp);
    @(posedge i_clk);
    #1;
    check(tag);
  endtask

  initial begin
    i_reset = 1'b1;
    i_A = 4'hF; i_B = 4'hF; i_Cin = 1'b0; i_sub = 1'b0;
    #1;

    step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, RST_VEC, "reset_0");
    step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, RST_VEC, "reset_1");
    step(1'b0, 4'hF, 4'hF, 1'b0, 1'b0, {4'hE, 1'b1, 1'b0, 1'b0}, "release_F+F");

    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, {4'h0, 1'b0, 1'b0, 1'b1}, "add_0+0");
    step(1'b0, 4'h3, 4'h4, 1'b0, 1'b0, {4'h7, 1'b0, 1'b0, 1'b0}, "add_3+4");
    step(1'b0, 4'hA, 4'hB, 1'b0, 1'b0, {4'h5, 1'b1, 1'b1, 1'b0}, "add_A+B");
    step(1'b0, 4'h5, 4'h9, 1'b0, 1'b0, {4'hE, 1'b0, 1'b0, 1'b0}, "add_5+9");
    step(1'b0, 4'h6, 4'h8, 1'b0, 1'b0, {4'hE, 1'b0, 1'b0, 1'b0}, "add_6+8");
    step(1'b0, 4'h7, 4'h7, 1'b0, 1'b0, {4'hE, 1'b0, 1'b1, 1'b0}, "add_7+7");
    step(1'b0, 4'h3, 4'h6, 1'b0, 1'b0, {4'h9, 1'b0, 1'b1, 1'b0}, "add_3+6");
    step(1'b0, 4'h2, 4'h5, 1'b0, 1'b0, {4'h7, 1'b0, 1'b0, 1'b0}, "add_2+5");

    step(1'b0, 4'hF, 4'h0, 1'b1, 1'b0, {4'h0, 1'b1, 1'b0, 1'b1}, "cin_F+0+1");
    step(1'b0, 4'h7, 4'h0, 1'b1, 1'b0, {4'h8, 1'b0, 1'b1, 1'b0}, "cin_7+0+1");

    step(1'b0, 4'h9, 4'h3, 1'b0, 1'b1, {4'h6, 1'b1, 1'b1, 1'b0}, "sub_9-3");
    step(1'b0, 4'h3, 4'h9, 1'b0, 1'b1, {4'hA, 1'b0, 1'b1, 1'b0}, "sub_3-9");
    step(1'b0, 4'h8, 4'h1, 1'b0, 1'b1, {4'h7, 1'b1, 1'b1, 1'b0}, "sub_8-1");
    step(1'b0, 4'h5, 4'h5, 1'b0, 1'b1, {4'h0, 1'b1, 1'b0, 1'b1}, "sub_5-5");
    step(1'b0, 4'h5, 4'h5, 1'b1, 1'b1, {4'hF, 1'b0, 1'b0, 1'b0}, "sub_5-5-1");

    step(1'b0, 4'h1, 4'h2, 1'b0, 1'b0, {4'h3, 1'b0, 1'b0, 1'b0}, "mid_1+2");
    step(1'b1, 4'h4, 4'h4, 1'b0, 1'b0, RST_VEC,                  "mid_reset");
    step(1'b0, 4'h5, 4'h6, 1'b0, 1'b0, {4'hB, 1'b0, 1'b1, 1'b0}, "mid_5+6");
    step(1'b0, 4'h2, 4'h2, 1'b0, 1'b0, {4'h4, 1'b0, 1'b0, 1'b0}, "mid_2+2");

    for (int k = 0; k < 1024; k++) begin
      logic [9:0] v;
      v = 10'(k);
      step(1'b0, v[3:0], v[7:4], v[8], v[9],
           model(v[3:0], v[7:4], v[8], v[9]), "exhaustive");
    end

    // a random burst exercising back-to-back mode switches
    for (int k = 0; k < 64; k++) begin
      logic [3:0] a, b;
      logic cin, sub;
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      step(1'b0, a, b, cin, sub, model(a, b, cin, sub), "random");
    end

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
